// File: rtl/video_scan_fetch_pkg.sv
// video_scan_fetch_pkg: shared widths and bpp helpers for the scan-out fetch engine
package video_scan_fetch_pkg;
  localparam int BC_W = 9;
  function automatic int ppbOf(input int bpp);
    return 8 / bpp;
  endfunction
  function automatic int pcWidthOf(input int bpp);
    return (bpp == 4) ? 1 : (bpp == 2) ? 2 : 3;
  endfunction
  function automatic bit bppLegal(input int bpp);
    return bpp == 1 || bpp == 2 || bpp == 4;
  endfunction
endpackage

// File: rtl/video_scan_fetch_serializer.sv
// video_scan_fetch_serializer: byte hold/shift register turning fetched bytes into BPP-bit pixels
//  clk, rst_n        clock, async active-low reset
//  visible           active pixel window
//  lineStart         restarts the pixel phase
//  rStrobe, rData    RAM read strobe and data (data captured one cycle after strobe)
//  byteOk            a fetched byte is available at this byte slot
//  ovrIn             first byte slot past the fetched line
//  pcZero            pixel phase is at a byte boundary
//  pixel, valid, overrun  registered outputs
module video_scan_fetch_serializer
  import video_scan_fetch_pkg::*;
#(
  parameter int BPP    = 1,
  parameter int INVERT = 1,
  parameter int BORDER = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           visible,
  input  logic           lineStart,
  input  logic           rStrobe,
  input  logic [7:0]     rData,
  input  logic           byteOk,
  input  logic           ovrIn,
  output logic           pcZero,
  output logic [BPP-1:0] pixel,
  output logic           valid,
  output logic           overrun
);
  localparam int PPB = ppbOf(BPP);
  localparam int PC_W = pcWidthOf(BPP);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PPB - 1);
  localparam logic [BPP-1:0] INV_MASK = {BPP{1'(INVERT)}};
  localparam logic [BPP-1:0] BORDER_PX = BPP'(BORDER);
  logic [7:0] hold, sr;
  logic [PC_W-1:0] pc;
  logic rdPend, shown;
  logic [BPP-1:0] holdPx, srPx;
  // polarity only touches fetched data; border bypasses the mask
  assign holdPx = hold[7 -: BPP] ^ INV_MASK;
  assign srPx = sr[7 -: BPP] ^ INV_MASK;
  assign pcZero = pc == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
      sr <= '0;
      pc <= '0;
      rdPend <= 1'b0;
      shown <= 1'b0;
      pixel <= '0;
      valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      rdPend <= rStrobe;
      if (rdPend) hold <= rData;
      valid <= visible;
      overrun <= ovrIn;
      pc <= (!visible || lineStart || pc == PC_LAST) ? '0 : pc + 1'b1;
      // shown remembers whether the current byte slot carries real data or border
      if (visible && pcZero) begin
        shown <= byteOk;
        sr <= hold << BPP;
        pixel <= byteOk ? holdPx : BORDER_PX;
      end else if (visible) begin
        sr <= sr << BPP;
        pixel <= shown ? srPx : BORDER_PX;
      end else begin
        pixel <= '0;
      end
    end
  end
endmodule

// File: rtl/video_scan_fetch.sv
// video_scan_fetch: scan-out fetch engine between video RAM read port and the timing generator
//  clk, rst_n          clock, async active-low reset
//  frame_start         first-line pulse, reloads BASE_ADDR
//  line_start          hblank pulse, fetches byte 0 of the current row
//  visible             active pixel window
//  r_addr, r_strobe    RAM read request (combinational; data returns next cycle)
//  r_data              RAM read data
//  pixel, valid        registered pixel and visible copy
//  overrun             pulse on first visible pixel past the fetched line
module video_scan_fetch
  import video_scan_fetch_pkg::*;
#(
  parameter int ADDR_W      = 13,
  parameter int BPP         = 1,
  parameter int LINE_BYTES  = 40,
  parameter int STRIDE      = 40,
  parameter int LINE_REPEAT = 1,
  parameter int BASE_ADDR   = 0,
  parameter int INVERT      = 1,
  parameter int BORDER      = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              visible,
  output logic [ADDR_W-1:0] r_addr,
  output logic              r_strobe,
  input  logic [7:0]        r_data,
  output logic [BPP-1:0]    pixel,
  output logic              valid,
  output logic              overrun
);
  if (!bppLegal(BPP)) begin : gBadBpp
    $error("video_scan_fetch: BPP must be 1, 2 or 4");
  end
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);
  localparam logic [BC_W-1:0] LB = BC_W'(LINE_BYTES);
  localparam logic [BC_W-1:0] LB_OVR = BC_W'(LINE_BYTES + 1);
  localparam logic [2:0] REP_LAST = 3'(LINE_REPEAT - 1);
  logic [ADDR_W-1:0] rowAddr, fetchAddr, startAddr;
  logic [2:0] rep;
  logic [BC_W-1:0] bc;
  logic act, visPrev, pcZero, byteSlot, byteOk, fetchNext, ovr, fall;
  // bc counts bytes fetched; LB+1 marks the overrun slot, LB+2 parks it so overrun fires once
  always_comb begin
    startAddr = frame_start ? BASE : rowAddr;
    byteSlot = visible & pcZero & act;
    byteOk = byteSlot & (bc <= LB);
    fetchNext = byteOk & (bc < LB);
    ovr = byteSlot & (bc == LB_OVR);
    fall = visPrev & ~visible;
    r_strobe = rst_n & (line_start | fetchNext);
    r_addr = !r_strobe ? '0 : line_start ? startAddr : fetchAddr;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rowAddr <= '0;
      fetchAddr <= '0;
      rep <= '0;
      bc <= '0;
      act <= 1'b0;
      visPrev <= 1'b0;
    end else begin
      visPrev <= visible;
      if (line_start) begin
        act <= 1'b1;
        bc <= BC_W'(1);
        fetchAddr <= startAddr + 1'b1;
      end else begin
        if (fall) act <= 1'b0;
        if (byteOk || ovr) bc <= bc + 1'b1;
        if (fetchNext) fetchAddr <= fetchAddr + 1'b1;
      end
      if (frame_start) begin
        rowAddr <= BASE;
        rep <= '0;
      end else if (fall) begin
        rep <= (rep == REP_LAST) ? '0 : rep + 1'b1;
        rowAddr <= (rep == REP_LAST) ? rowAddr + STEP : rowAddr;
      end
    end
  end
  video_scan_fetch_serializer #(
    .BPP(BPP),
    .INVERT(INVERT),
    .BORDER(BORDER)
  ) uSer (
    .clk(clk),
    .rst_n(rst_n),
    .visible(visible),
    .lineStart(line_start),
    .rStrobe(r_strobe),
    .rData(r_data),
    .byteOk(byteOk),
    .ovrIn(ovr),
    .pcZero(pcZero),
    .pixel(pixel),
    .valid(valid),
    .overrun(overrun)
  );
endmodule

// File: tb/tb_video_scan_fetch.sv
// tb_video_scan_fetch: directed checks of four video_scan_fetch configurations sharing one timing stream
module tb_video_scan_fetch;
  logic clk = 1'b0;
  logic rst_n, frameStart, lineStart, visible;
  logic [12:0] ra [4];
  logic rs [4];
  logic [7:0] rd [4];
  logic vl [4];
  logic ov [4];
  logic [3:0] pxv [4];
  logic [0:0] pix0, pix2, pix3;
  logic [1:0] pix1;
  logic [3:0] px [4][400];
  logic [12:0] ad [4][64];
  int pxN [4], adN [4], ovN [4], ovAt [4];
  int cyc, firstVis, firstVal, checks, errors, bad;
  always #5 clk = ~clk;
  assign pxv[0] = {3'b000, pix0};
  assign pxv[1] = {2'b00, pix1};
  assign pxv[2] = {3'b000, pix2};
  assign pxv[3] = {3'b000, pix3};
  video_scan_fetch u0 (
    .clk(clk), .rst_n(rst_n), .frame_start(frameStart), .line_start(lineStart), .visible(visible),
    .r_addr(ra[0]), .r_strobe(rs[0]), .r_data(rd[0]), .pixel(pix0), .valid(vl[0]), .overrun(ov[0])
  );
  video_scan_fetch #(.BPP(2), .LINE_BYTES(2), .INVERT(0), .BORDER(2)) u1 (
    .clk(clk), .rst_n(rst_n), .frame_start(frameStart), .line_start(lineStart), .visible(visible),
    .r_addr(ra[1]), .r_strobe(rs[1]), .r_data(rd[1]), .pixel(pix1), .valid(vl[1]), .overrun(ov[1])
  );
  video_scan_fetch #(.LINE_REPEAT(3)) u2 (
    .clk(clk), .rst_n(rst_n), .frame_start(frameStart), .line_start(lineStart), .visible(visible),
    .r_addr(ra[2]), .r_strobe(rs[2]), .r_data(rd[2]), .pixel(pix2), .valid(vl[2]), .overrun(ov[2])
  );
  video_scan_fetch #(.BASE_ADDR(13'h1FF0)) u3 (
    .clk(clk), .rst_n(rst_n), .frame_start(frameStart), .line_start(lineStart), .visible(visible),
    .r_addr(ra[3]), .r_strobe(rs[3]), .r_data(rd[3]), .pixel(pix3), .valid(vl[3]), .overrun(ov[3])
  );
  function automatic logic [7:0] memA(input logic [12:0] a);
    return a[0] ? 8'hFF : 8'h00;
  endfunction
  function automatic logic [7:0] memB(input logic [12:0] a);
    return (a == 13'd0) ? 8'h1B : (a == 13'd1) ? 8'hE4 : 8'h5A;
  endfunction
  always @(posedge clk)
    for (int i = 0; i < 4; i++) if (rs[i]) rd[i] <= (i == 1) ? memB(ra[i]) : memA(ra[i]);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic cycle(input logic ls, input logic fs, input logic v);
    lineStart = ls;
    frameStart = fs;
    visible = v;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (rs[i]) begin
        if (adN[i] < 64) ad[i][adN[i]] = ra[i];
        adN[i]++;
      end
      if (vl[i]) begin
        if (ov[i]) begin
          ovN[i]++;
          ovAt[i] = pxN[i];
        end
        if (pxN[i] < 400) px[i][pxN[i]] = pxv[i];
        pxN[i]++;
      end
    end
    if (v && firstVis < 0) firstVis = cyc;
    if (vl[0] && firstVal < 0) firstVal = cyc;
    cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic clearCap();
    for (int i = 0; i < 4; i++) begin
      pxN[i] = 0;
      adN[i] = 0;
      ovN[i] = 0;
      ovAt[i] = -1;
    end
    cyc = 0;
    firstVis = -1;
    firstVal = -1;
  endtask
  task automatic doLine(input logic fs, input int n);
    clearCap();
    cycle(1'b1, fs, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    repeat (n) cycle(1'b0, 1'b0, 1'b1);
    repeat (4) cycle(1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    frameStart = 1'b0;
    lineStart = 1'b0;
    visible = 1'b0;
    clearCap();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst pixel", 32'(pix0), 0);
    check("rst valid", 32'(vl[0]), 0);
    check("rst overrun", 32'(ov[0]), 0);
    check("rst strobe", 32'(rs[0]), 0);
    check("rst addr", 32'(ra[0]), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    doLine(1'b1, 330);
    check("u0 fetch count", adN[0], 40);
    bad = 0;
    for (int k = 0; k < 40; k++) if (ad[0][k] != 13'(k)) bad++;
    check("u0 addr seq", bad, 0);
    check("u0 px count", pxN[0], 330);
    check("u0 latency", firstVal - firstVis, 1);
    check("u0 px0", 32'(px[0][0]), 1);
    check("u0 px8", 32'(px[0][8]), 0);
    bad = 0;
    for (int k = 0; k < 320; k++) if (px[0][k] != (((k / 8) % 2 == 0) ? 4'd1 : 4'd0)) bad++;
    check("u0 px pattern", bad, 0);
    bad = 0;
    for (int k = 320; k < 330; k++) if (px[0][k] != 4'd0) bad++;
    check("u0 border", bad, 0);
    check("u0 ovr count", ovN[0], 1);
    check("u0 ovr at", ovAt[0], 320);
    check("u1 fetch count", adN[1], 2);
    check("u1 addr1", 32'(ad[1][1]), 1);
    check("u1 px0", 32'(px[1][0]), 0);
    check("u1 px1", 32'(px[1][1]), 1);
    check("u1 px2", 32'(px[1][2]), 2);
    check("u1 px3", 32'(px[1][3]), 3);
    check("u1 px4", 32'(px[1][4]), 3);
    check("u1 px7", 32'(px[1][7]), 0);
    bad = 0;
    for (int k = 8; k < 330; k++) if (px[1][k] != 4'd2) bad++;
    check("u1 border", bad, 0);
    check("u1 ovr at", ovAt[1], 8);
    check("u1 ovr count", ovN[1], 1);
    check("u2 line0 addr", 32'(ad[2][0]), 0);
    check("u3 addr15", 32'(ad[3][15]), 32'h1FFF);
    check("u3 addr16", 32'(ad[3][16]), 0);
    check("u3 addr39", 32'(ad[3][39]), 32'h17);
    doLine(1'b0, 320);
    check("u2 line1 addr", 32'(ad[2][0]), 0);
    check("u0 line1 addr", 32'(ad[0][0]), 40);
    check("u0 line1 ovr", ovN[0], 0);
    doLine(1'b0, 320);
    check("u2 line2 addr", 32'(ad[2][0]), 0);
    check("u2 line2 last", 32'(ad[2][39]), 39);
    doLine(1'b0, 320);
    check("u2 line3 addr", 32'(ad[2][0]), 40);
    check("u2 line3 last", 32'(ad[2][39]), 79);
    check("u0 line3 addr", 32'(ad[0][0]), 120);
    check("idle pixel", 32'(pix0), 0);
    check("idle valid", 32'(vl[0]), 0);
    doLine(1'b1, 320);
    check("u2 frame addr", 32'(ad[2][0]), 0);
    check("u0 frame addr", 32'(ad[0][0]), 0);
    clearCap();
    cycle(1'b1, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    repeat (50) cycle(1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      check("midrst strobe", 32'(rs[0]), 0);
      check("midrst pixel", 32'(pix0), 0);
      check("midrst valid", 32'(vl[0]), 0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    repeat (20) cycle(1'b0, 1'b0, 1'b1);
    repeat (4) cycle(1'b0, 1'b0, 1'b0);
    doLine(1'b1, 320);
    check("post rst count", adN[0], 40);
    check("post rst addr0", 32'(ad[0][0]), 0);
    check("post rst addr39", 32'(ad[0][39]), 39);
    bad = 0;
    for (int k = 0; k < 320; k++) if (px[0][k] != (((k / 8) % 2 == 0) ? 4'd1 : 4'd0)) bad++;
    check("post rst pattern", bad, 0);
    check("post rst px count", pxN[0], 320);
    check("post rst u1 px1", 32'(px[1][1]), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
